unified_slow_memory: RTL

Parametrised multi-channel behavioural line memory for the CHIP simulation environment, the next generation of the single-channel slow memory model. It serves NCH independent cache-line request channels (e.g. I-cache and D-cache sharing one backing store) through a round-robin arbiter. Read and write latencies are configurable, and the block adds abort handling and a sticky protocol-error flag. It is instantiated in the top-level bench alongside CHIP and TestBed. Its array is preloaded by the bench through the hierarchical name `mem`.

---
 rtl/mem_model_pkg.sv | 19 +
 rtl/unified_slow_memory_rr_arbiter.sv | 43 ++++
 rtl/unified_slow_memory.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_model_pkg.sv
// Shared types for the behavioural line-memory models.
// Holds default widths, FSM states and the request op.
package mem_model_pkg;

  localparam int LINE_W_D = 128;
  localparam int ADDR_W_D = 28;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic {
    RD,
    WR
  } op_t;

endpackage

// File: rtl/unified_slow_memory_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer,
// pointer moves past the winner when upd is asserted.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          upd,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gidx,
  output logic          valid
);

  logic [PW-1:0] r_ptr;
  int            w_j;

  always_comb begin
    gidx  = '0;
    valid = 1'b0;
    gnt   = '0;
    w_j   = 0;
    for (int i = 0; i < N; i++) begin
      w_j = (int'(r_ptr) + i) % N;
      if (!valid && req[w_j]) begin
        valid = 1'b1;
        gidx  = PW'(w_j);
      end
    end
    if (valid) gnt[gidx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (upd && valid) begin
      r_ptr <= (gidx == PW'(N - 1)) ? '0
                                    : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/unified_slow_memory.sv
// Multi-channel behavioural line memory with round-robin
// arbitration, per-op latency, abort and sticky error.
module unified_slow_memory
  import mem_model_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int LINE_W = LINE_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DEPTH  = 256,
  parameter int LAT_RD = 4,
  parameter int LAT_WR = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      mem_read,
  input  logic [NCH-1:0]      mem_write,
  input  logic [NCH*ADDR_W-1:0] mem_addr,
  input  logic [NCH*LINE_W-1:0] mem_wdata,
  output logic [NCH*LINE_W-1:0] mem_rdata,
  output logic [NCH-1:0]      mem_ready,
  output logic                busy,
  output logic                err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = 16;

  reg [LINE_W-1:0] mem [0:DEPTH-1];

  state_t          r_state;
  state_t          w_next;
  op_t             r_op;
  logic [GW-1:0]   r_gnt;
  logic [NCH-1:0]  r_gnt_oh;
  logic [IW-1:0]   r_idx;
  logic [LINE_W-1:0] r_wdata;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic [LINE_W-1:0] r_rdata [NCH];

  logic [IW-1:0]   w_idx   [NCH];
  logic [LINE_W-1:0] w_wdata [NCH];
  logic [NCH-1:0]  w_req;
  logic [NCH-1:0]  w_gnt;
  logic [GW-1:0]   w_gidx;
  logic            w_valid;
  logic            w_accept;
  logic            w_fire;
  logic            w_hold;
  logic            w_unused_addr;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_idx[c]   = mem_addr[c*ADDR_W +: IW];
    assign w_wdata[c] = mem_wdata[c*LINE_W +: LINE_W];
    assign mem_rdata[c*LINE_W +: LINE_W] = r_rdata[c];
  end

  // Upper address bits only alias onto the array.
  assign w_unused_addr = ^mem_addr;

  assign w_req  = mem_read | mem_write;
  assign w_hold = mem_read[r_gnt] | mem_write[r_gnt];

  rr_arbiter #(
    .N  (NCH),
    .PW (GW)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_req),
    .upd   (w_accept),
    .gnt   (w_gnt),
    .gidx  (w_gidx),
    .valid (w_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_fire   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: begin
        // A dropped request aborts even on the final count.
        if (!w_hold) begin
          w_next = IDLE;
        end else if (r_cnt == '0) begin
          w_fire = 1'b1;
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= RD;
      r_gnt    <= '0;
      r_gnt_oh <= '0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < NCH; i++) r_rdata[i] <= '0;
    end else begin
      if (w_accept) begin
        r_gnt    <= w_gidx;
        r_gnt_oh <= w_gnt;
        r_idx    <= w_idx[w_gidx];
        r_wdata  <= w_wdata[w_gidx];
        if (mem_write[w_gidx]) begin
          r_op  <= WR;
          r_cnt <= CW'(LAT_WR - 1);
        end else begin
          r_op  <= RD;
          r_cnt <= CW'(LAT_RD - 1);
        end
        if (mem_read[w_gidx] && mem_write[w_gidx])
          r_err <= 1'b1;
      end else if (r_state == BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_fire && r_op == RD)
        r_rdata[r_gnt] <= mem[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && r_op == WR)
      mem[r_idx] <= r_wdata;
  end

  assign mem_ready = (r_state == RESP) ? r_gnt_oh : '0;
  assign busy      = (r_state != IDLE);
  assign err       = r_err;

endmodule
